// File: rtl/uart_log_pkg.sv
//==============================================================================
// uart_log_pkg: shared widths, defaults and helpers for the UART log arbiter (rev 1.0)
//==============================================================================
`default_nettype none

package uart_log_pkg;
  localparam int LOG_W            = 16;
  localparam int DROP_W           = 16;
  localparam int DEF_N_REQ        = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  // Sources are capped at 8, so an 8-bit input covers every configuration.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// rr_arbiter: cyclic first-after-pointer grant over a request vector (rev 1.0)
//==============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_grant
);

  logic [IW-1:0] idx;

  // Search starts one past the last winner, so the pointer itself has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (en && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_log_arbiter.sv
//==============================================================================
// uart_log_arbiter: per-source holds, round-robin FIFO writes, slotted UART reads (rev 1.0)
//==============================================================================
`default_nettype none

module uart_log_arbiter
  import uart_log_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                   clk_48,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_strobe,
  input  logic [LOG_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [LOG_W-1:0]       fifo_write_data,
  output logic                   fifo_write_strobe,
  input  logic                   fifo_full,
  input  logic                   fifo_data_available,
  output logic                   fifo_read_strobe,
  input  logic                   uart_txd_ready,
  output logic                   uart_txd_strobe,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] hold_full;
  logic [LOG_W-1:0] hold_data [N_REQ];
  logic [IW-1:0]    ptr;
  logic [7:0]       starve_cnt;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             any_grant;

  logic             write_elig;
  logic             read_elig;
  logic             force_read;
  logic             do_read;
  logic             do_write;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] drops;
  logic [7:0]       drops8;
  logic [DROP_W:0]  drop_sum;

  // uart_txd_ready lags the load by a cycle, so our own last strobe blocks the slot.
  always_comb begin
    write_elig = (|hold_full) && !fifo_full;
    read_elig  = fifo_data_available && uart_txd_ready && !uart_txd_strobe;
    force_read = read_elig && (starve_cnt == 8'(STARVE_LIMIT));
    do_read    = read_elig && (!write_elig || force_read);
    do_write   = write_elig && !do_read;
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arbiter (
    .req       (hold_full),
    .ptr       (ptr),
    .en        (do_write),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A hold being drained this cycle can take a new word at the same edge.
  always_comb begin
    accept   = req_strobe & (~hold_full | grant);
    drops    = req_strobe & hold_full & ~grant;
    drops8   = '0;
    drops8[N_REQ-1:0] = drops;
    drop_sum = {1'b0, drop_count} + (DROP_W+1)'(popcount(drops8));
  end

  always_ff @(posedge clk_48) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        hold_data[i] <= req_data[LOG_W*i +: LOG_W];
      end
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      hold_full         <= '0;
      ptr               <= IW'(N_REQ - 1);
      starve_cnt        <= '0;
      fifo_write_data   <= '0;
      fifo_write_strobe <= 1'b0;
      fifo_read_strobe  <= 1'b0;
      uart_txd_strobe   <= 1'b0;
      drop_count        <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          hold_full[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_full[i] <= 1'b0;
        end
      end

      fifo_write_strobe <= any_grant;
      if (any_grant) begin
        fifo_write_data <= hold_data[grant_idx];
        ptr             <= grant_idx;
      end

      fifo_read_strobe <= do_read;
      uart_txd_strobe  <= do_read;

      if (do_read) begin
        starve_cnt <= '0;
      end else if (read_elig && do_write) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      drop_count <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  assign req_ready = ~hold_full;

endmodule

`default_nettype wire

// File: tb/tb_uart_log_arbiter.sv
//==============================================================================
// tb_uart_log_arbiter: directed vector table plus multi-cycle corner sequences (rev 1.0)
//==============================================================================
`default_nettype none

module tb_uart_log_arbiter;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic [3:0]  req_strobe;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] fifo_write_data;
  logic        fifo_write_strobe;
  logic        fifo_full;
  logic        fifo_data_available;
  logic        fifo_read_strobe;
  logic        uart_txd_ready;
  logic        uart_txd_strobe;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  always #5 clk_48 = ~clk_48;

  uart_log_arbiter #(
    .N_REQ        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk_48              (clk_48),
    .reset               (reset),
    .req_strobe          (req_strobe),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .fifo_write_data     (fifo_write_data),
    .fifo_write_strobe   (fifo_write_strobe),
    .fifo_full           (fifo_full),
    .fifo_data_available (fifo_data_available),
    .fifo_read_strobe    (fifo_read_strobe),
    .uart_txd_ready      (uart_txd_ready),
    .uart_txd_strobe     (uart_txd_strobe),
    .drop_count          (drop_count)
  );

  typedef struct {
    logic [3:0]  stb;
    logic [15:0] base;
    logic        full;
    logic        avail;
    logic        txr;
    logic        ewr;
    logic [15:0] ewd;
    logic        erd;
    logic [3:0]  erdy;
    logic [15:0] edrop;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(logic [3:0] stb, logic [15:0] base, logic full, logic avail,
                              logic txr, logic ewr, logic [15:0] ewd, logic erd,
                              logic [3:0] erdy, logic [15:0] edrop);
    vec_t v;
    v.stb = stb; v.base = base; v.full = full; v.avail = avail; v.txr = txr;
    v.ewr = ewr; v.ewd = ewd; v.erd = erd; v.erdy = erdy; v.edrop = edrop;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] stb, input logic [15:0] base);
    req_strobe = stb;
    for (int i = 0; i < 4; i++) req_data[16*i +: 16] = base + 16'(i);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ready"}, 32'(req_ready), 32'hF);
    chk({tag, " wr"},    32'(fifo_write_strobe), 32'h0);
    chk({tag, " rd"},    32'(fifo_read_strobe), 32'h0);
    chk({tag, " txs"},   32'(uart_txd_strobe), 32'h0);
    chk({tag, " wdata"}, 32'(fifo_write_data), 32'h0);
    chk({tag, " drop"},  32'(drop_count), 32'h0);
  endtask

  task automatic do_reset();
    drive(4'h0, 16'h0);
    fifo_full = 1'b0; fifo_data_available = 1'b0; uart_txd_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int wr_before, wr_between, nreads, overlap, b2b, wr_after;
    logic prev_rd;

    // stb, base, full, avail, txr | wr, wdata, rd, ready, drop
    vecs[0]  = mk(4'h1, 16'h3132, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hE, 16'd0);
    vecs[1]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h3132, 0, 4'hF, 16'd0);
    vecs[2]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hF, 16'd0);
    vecs[3]  = mk(4'hF, 16'h4100, 0, 0, 0, 1'b0, 16'h0000, 0, 4'h0, 16'd0);
    vecs[4]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h4101, 0, 4'h2, 16'd0);
    vecs[5]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h4102, 0, 4'h6, 16'd0);
    vecs[6]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h4103, 0, 4'hE, 16'd0);
    vecs[7]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h4100, 0, 4'hF, 16'd0);
    vecs[8]  = mk(4'h0, 16'h0000, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hF, 16'd0);
    vecs[9]  = mk(4'h2, 16'h5000, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hD, 16'd0);
    vecs[10] = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h5001, 0, 4'hF, 16'd0);
    vecs[11] = mk(4'h5, 16'h5100, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hA, 16'd0);
    vecs[12] = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h5102, 0, 4'hE, 16'd0);
    vecs[13] = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h5100, 0, 4'hF, 16'd0);
    vecs[14] = mk(4'h2, 16'h6000, 1, 0, 0, 1'b0, 16'h0000, 0, 4'hD, 16'd0);
    vecs[15] = mk(4'h2, 16'h6100, 1, 0, 0, 1'b0, 16'h0000, 0, 4'hD, 16'd1);
    vecs[16] = mk(4'h2, 16'h6200, 1, 0, 0, 1'b0, 16'h0000, 0, 4'hD, 16'd2);
    vecs[17] = mk(4'h0, 16'h0000, 1, 0, 0, 1'b0, 16'h0000, 0, 4'hD, 16'd2);
    vecs[18] = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h6001, 0, 4'hF, 16'd2);
    vecs[19] = mk(4'h0, 16'h0000, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hF, 16'd2);
    vecs[20] = mk(4'h2, 16'h7000, 0, 0, 0, 1'b0, 16'h0000, 0, 4'hD, 16'd2);
    vecs[21] = mk(4'h2, 16'h7100, 0, 0, 0, 1'b1, 16'h7001, 0, 4'hD, 16'd2);
    vecs[22] = mk(4'h0, 16'h0000, 0, 0, 0, 1'b1, 16'h7101, 0, 4'hF, 16'd2);
    vecs[23] = mk(4'h0, 16'h0000, 0, 1, 1, 1'b0, 16'h0000, 1, 4'hF, 16'd2);
    vecs[24] = mk(4'h0, 16'h0000, 0, 1, 1, 1'b0, 16'h0000, 0, 4'hF, 16'd2);
    vecs[25] = mk(4'h0, 16'h0000, 0, 1, 1, 1'b0, 16'h0000, 1, 4'hF, 16'd2);
    vecs[26] = mk(4'h0, 16'h0000, 0, 0, 1, 1'b0, 16'h0000, 0, 4'hF, 16'd2);

    req_data = '0;
    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].stb, vecs[i].base);
      fifo_full           = vecs[i].full;
      fifo_data_available = vecs[i].avail;
      uart_txd_ready      = vecs[i].txr;
      tick();
      chk($sformatf("v%0d wr", i),    32'(fifo_write_strobe), 32'(vecs[i].ewr));
      chk($sformatf("v%0d rd", i),    32'(fifo_read_strobe),  32'(vecs[i].erd));
      chk($sformatf("v%0d txs", i),   32'(uart_txd_strobe),   32'(vecs[i].erd));
      chk($sformatf("v%0d ready", i), 32'(req_ready),         32'(vecs[i].erdy));
      chk($sformatf("v%0d drop", i),  32'(drop_count),        32'(vecs[i].edrop));
      if (vecs[i].ewr) chk($sformatf("v%0d wdata", i), 32'(fifo_write_data), 32'(vecs[i].ewd));
    end

    // Read starvation: continuous writes with a read always eligible.
    do_reset();
    drive(4'hF, 16'h8000);
    uart_txd_ready = 1'b1;
    tick();
    fifo_data_available = 1'b1;
    wr_before = 0; wr_between = 0; nreads = 0; overlap = 0; b2b = 0; prev_rd = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (fifo_read_strobe && fifo_write_strobe) overlap++;
      if (fifo_read_strobe && prev_rd) b2b++;
      if (fifo_read_strobe) nreads++;
      else if (fifo_write_strobe) begin
        if (nreads == 0) wr_before++;
        else if (nreads == 1) wr_between++;
      end
      prev_rd = fifo_read_strobe;
    end
    chk("starve overlap", 32'(overlap), 32'd0);
    chk("starve back2back", 32'(b2b), 32'd0);
    chk("starve reads", 32'(nreads), 32'd2);
    chk("starve writes before read", 32'(wr_before), 32'd8);
    chk("starve writes between reads", 32'(wr_between), 32'd9);

    // Drop saturation: 4 drops per cycle while the FIFO is full.
    do_reset();
    fifo_full = 1'b1;
    drive(4'hF, 16'h9000);
    tick();
    for (int k = 0; k < 16383; k++) tick();
    drive(4'h3, 16'h9100);
    tick();
    drive(4'h0, 16'h0);
    chk("drop at fffe", 32'(drop_count), 32'hFFFE);
    drive(4'h7, 16'h9200);
    tick();
    chk("drop saturate", 32'(drop_count), 32'hFFFF);
    drive(4'h1, 16'h9300);
    tick();
    chk("drop stays sat", 32'(drop_count), 32'hFFFF);
    chk("no write while full", 32'(fifo_write_strobe), 32'd0);

    // Reset mid-operation with all holds loaded and a write in flight.
    drive(4'h0, 16'h0);
    fifo_full = 1'b0;
    tick();
    chk("write before reset", 32'(fifo_write_strobe), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midreset");
    wr_after = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (fifo_write_strobe) wr_after++;
    end
    chk("no stale writes", 32'(wr_after), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_log_arbiter.md
# uart_log_arbiter

Shares the single-port SPRAM 16-to-8 log FIFO between several logging sources (SPI address hex dump, CS-edge newlines, overlay markers, status) and schedules FIFO drains into the UART transmitter. Each source gets a one-word holding register, so it can fire a one-cycle strobe without stalling. Writes are granted round-robin. Reads are slotted so that FIFO read and write never fall in the same cycle, and reads cannot be starved. It sits between the SPI monitor logic and `fifo_spram_16to8` / `uart_tx`.

## Interface
Parameters:
- `N_REQ`, default 4: number of logging sources, 2..8.
- `STARVE_LIMIT`, default 8: consecutive read-eligible cycles lost to writes before a read is forced, 1..255.

Ports:
- `clk_48`  in  1  48 MHz system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_strobe`  in  N_REQ  one-cycle "log this word" pulse per source.
- `req_data`  in  16*N_REQ  source i word in bits [16i+15:16i]; two ASCII bytes, high byte sent first.
- `req_ready`  out  N_REQ  holding register i empty (informational).
- `fifo_write_data`  out  16  word to the FIFO.
- `fifo_write_strobe`  out  1  FIFO write enable.
- `fifo_full`  in  1  FIFO cannot accept a word.
- `fifo_data_available`  in  1  FIFO has a byte to read.
- `fifo_read_strobe`  out  1  FIFO read enable.
- `uart_txd_ready`  in  1  UART idle.
- `uart_txd_strobe`  out  1  UART load; FIFO read_data is wired directly to the UART.
- `drop_count`  out  16  saturating count of discarded source words.

## Operation
- **Reset values:**
  - All holding registers are empty, so `req_ready` is all ones.
  - `fifo_write_strobe`, `fifo_read_strobe` and `uart_txd_strobe` are 0.
  - `fifo_write_data` is 0.
  - `drop_count` is 0.
  - The round-robin pointer is N_REQ-1, so source 0 has first priority.
  - The starvation counter is 0.
- **Capture:**
  - A `req_strobe[i]` with hold i empty loads `req_data[i]` into the hold and marks it full.
  - A `req_strobe[i]` with hold i full discards the word and adds 1 to `drop_count`.
  - Drops from several sources in one cycle add the number of drops. `drop_count` saturates at 0xFFFF.
- **Write slot:**
  - A write is eligible when any hold is full and `fifo_full` is 0.
  - The grant goes to the first full hold after the pointer, searching cyclically.
  - At the same edge: register the word to `fifo_write_data`, pulse `fifo_write_strobe`, clear that hold, and set the pointer to the granted index.
- **Read slot:** a read is eligible when all of the following hold:
  - `fifo_data_available` is 1;
  - `uart_txd_ready` is 1;
  - `uart_txd_strobe` was not asserted in the previous cycle, because UART ready drops one cycle late.
- **Issuing a read:** pulse `fifo_read_strobe` and `uart_txd_strobe` together for one cycle.
- **Arbitration between read and write:**
  - Read and write strobes are mutually exclusive in every cycle.
  - A write wins by default.
  - The starvation counter increments on every cycle in which a read was eligible but a write was issued.
  - When the counter equals `STARVE_LIMIT`, the next eligible read wins over any write, and the counter clears.
  - The counter also clears whenever a read is issued.
- **Backpressure:** while `fifo_full` is 1, no writes are issued. Holds keep their data, and new strobes to full holds are dropped.

## Timing
- **Source to FIFO latency:**
  - A strobe in cycle t into an empty hold, with no contention, gives `fifo_write_strobe` in cycle t+2.
  - Each competing full hold ahead in round-robin order adds one cycle.
  - A forced read adds one cycle.
- **Same-cycle drain and strobe:** a strobe arriving in the same cycle that its hold is granted is accepted, not dropped. The hold reloads at that edge.
- **`req_ready[i]`:** registered; it reflects hold state after the last edge.
- **Write throughput:** at most one FIFO write per cycle.
- **Read rate:** at most one read per two cycles. In practice reads are UART-paced: one byte per 10 `clk_1` bit times.
- **Mid-operation reset:**
  - All pending hold words are lost and not counted in `drop_count`.
  - Strobes in flight are deasserted the next cycle.

## Structure
- Package `uart_log_pkg` holds:
  - `LOG_W` = 16;
  - `DROP_W` = 16;
  - the default `N_REQ` and `STARVE_LIMIT`;
  - a `popcount` function for drop accumulation.
- Sub-module `rr_arbiter`:
  - parameterised by `N_REQ`;
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant, grant index, any-grant.
  - It is instantiated once.
- Holds, read/write slot logic and counters stay in `uart_log_arbiter`.

## Test plan
- **Single source, uncontended:** after reset, `req_strobe[0]` with 0x3132, FIFO empty and not full. `fifo_write_strobe` is high exactly 2 cycles later with data 0x3132, and `req_ready[0]` returns to 1.
- **Round-robin fairness:** all 4 sources strobe 0x4100+i in one cycle. Writes occur in consecutive cycles, ordered 0,1,2,3. A second burst after a grant to 1 starts with source 2.
- **Drop on full hold:** hold `fifo_full`=1 and strobe source 1 three times. The first word is held, `drop_count` is 2, and no write occurs. Release `fifo_full`: exactly one write, of the first word.
- **Read slot exclusion:** continuous strobes on all sources with `fifo_data_available`=1 and `uart_txd_ready`=1:
  - `fifo_read_strobe` and `fifo_write_strobe` are never high in the same cycle;
  - a read is forced after 8 lost cycles;
  - there are no reads in back-to-back cycles.
- **Drop saturation:** preload `drop_count` near 0xFFFE by forcing 0xFFFE drops, then drop from 3 sources in one cycle. `drop_count` reads 0xFFFF.
- **Reset mid-operation:** fill all holds, assert `reset` for 1 cycle. All outputs return to their reset values, `drop_count` is 0, and no write of the old data appears afterwards.
